// File: rtl/vx_mem_bridge.sv
// Vortex tagged memory port to in-order untagged external channel: one-cycle request and response registers, in-order tag FIFO, read credit limit.
// Optional perf counters under VX_MEM_BRIDGE_PERF_EN; readies are forced low while reset is high.
module vx_mem_bridge #(
   parameter int DATA_WIDTH  = 512,
   parameter int ADDR_WIDTH  = 26,
   parameter int TAG_WIDTH   = 8,
   parameter int MAX_PENDING = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    vx_mem_req_valid,
   output logic                    vx_mem_req_ready,
   input  logic                    vx_mem_req_rw,
   input  logic [DATA_WIDTH/8-1:0] vx_mem_req_byteen,
   input  logic [ADDR_WIDTH-1:0]   vx_mem_req_addr,
   input  logic [DATA_WIDTH-1:0]   vx_mem_req_data,
   input  logic [TAG_WIDTH-1:0]    vx_mem_req_tag,
   output logic                    vx_mem_rsp_valid,
   input  logic                    vx_mem_rsp_ready,
   output logic [DATA_WIDTH-1:0]   vx_mem_rsp_data,
   output logic [TAG_WIDTH-1:0]    vx_mem_rsp_tag,
   output logic                    ext_req_valid,
   input  logic                    ext_req_ready,
   output logic                    ext_req_rw,
   output logic [DATA_WIDTH/8-1:0] ext_req_byteen,
   output logic [ADDR_WIDTH-1:0]   ext_req_addr,
   output logic [DATA_WIDTH-1:0]   ext_req_data,
   input  logic                    ext_rsp_valid,
   output logic                    ext_rsp_ready,
   input  logic [DATA_WIDTH-1:0]   ext_rsp_data,
   output logic                    busy,
   output logic                    rsp_underflow
`ifdef VX_MEM_BRIDGE_PERF_EN
   ,
   output logic [31:0]             perf_reads,
   output logic [31:0]             perf_writes,
   output logic [31:0]             perf_stalls
`endif
);

   localparam int PTR_W = $clog2(MAX_PENDING);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CREDITS = CNT_W'(MAX_PENDING);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   logic                    req_q_valid;
   logic                    req_q_rw;
   logic [DATA_WIDTH/8-1:0] req_q_byteen;
   logic [ADDR_WIDTH-1:0]   req_q_addr;
   logic [DATA_WIDTH-1:0]   req_q_data;
   logic                    rsp_q_valid;
   logic [DATA_WIDTH-1:0]   rsp_q_data;
   logic [TAG_WIDTH-1:0]    rsp_q_tag;
   logic [CNT_W-1:0]        pending;
   logic [CNT_W-1:0]        fifo_cnt;
   logic [PTR_W-1:0]        wr_ptr;
   logic [PTR_W-1:0]        rd_ptr;
   logic [TAG_WIDTH-1:0]    tag_mem [MAX_PENDING];
   logic                    underflow_q;

   logic req_fire, rd_fire, ext_req_fire, ext_rsp_fire, vx_rsp_fire, fifo_empty, tag_pop;

   assign req_fire     = vx_mem_req_valid && vx_mem_req_ready;
   assign rd_fire      = req_fire && !vx_mem_req_rw;
   assign ext_req_fire = req_q_valid && ext_req_ready;
   assign ext_rsp_fire = ext_rsp_valid && ext_rsp_ready;
   assign vx_rsp_fire  = rsp_q_valid && vx_mem_rsp_ready;
   assign fifo_empty   = (fifo_cnt == '0);
   assign tag_pop      = ext_rsp_fire && !fifo_empty;

   // Credits only gate reads: writes never come back, so they cannot exhaust the tag FIFO.
   assign vx_mem_req_ready = !reset && (!req_q_valid || ext_req_ready)
                             && (vx_mem_req_rw || pending < CREDITS);
   assign ext_rsp_ready    = !reset && (!rsp_q_valid || vx_mem_rsp_ready);

   assign ext_req_valid    = req_q_valid;
   assign ext_req_rw       = req_q_rw;
   assign ext_req_byteen   = req_q_byteen;
   assign ext_req_addr     = req_q_addr;
   assign ext_req_data     = req_q_data;
   assign vx_mem_rsp_valid = rsp_q_valid;
   assign vx_mem_rsp_data  = rsp_q_data;
   assign vx_mem_rsp_tag   = rsp_q_tag;
   assign busy             = req_q_valid || (pending != '0);
   assign rsp_underflow    = underflow_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         req_q_valid <= 1'b0;
         rsp_q_valid <= 1'b0;
         pending     <= '0;
         fifo_cnt    <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         underflow_q <= 1'b0;
      end else begin
         if (req_fire)
            req_q_valid <= 1'b1;
         else if (ext_req_fire)
            req_q_valid <= 1'b0;

         if (ext_rsp_fire)
            rsp_q_valid <= 1'b1;
         else if (vx_rsp_fire)
            rsp_q_valid <= 1'b0;

         if (rd_fire)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (tag_pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         if (ext_rsp_fire && fifo_empty)
            underflow_q <= 1'b1;

         case ({rd_fire, tag_pop})
            2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
            2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
            default: fifo_cnt <= fifo_cnt;
         endcase

         // An orphan response after underflow must not drive the credit count negative.
         case ({rd_fire, vx_rsp_fire})
            2'b10:   pending <= pending + CNT_ONE;
            2'b01:   pending <= (pending != '0) ? pending - CNT_ONE : pending;
            default: pending <= pending;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (req_fire) begin
         req_q_rw     <= vx_mem_req_rw;
         req_q_byteen <= vx_mem_req_byteen;
         req_q_addr   <= vx_mem_req_addr;
         req_q_data   <= vx_mem_req_data;
      end
      if (ext_rsp_fire) begin
         rsp_q_data <= ext_rsp_data;
         rsp_q_tag  <= fifo_empty ? '0 : tag_mem[rd_ptr];
      end
      if (rd_fire)
         tag_mem[wr_ptr] <= vx_mem_req_tag;
   end

`ifdef VX_MEM_BRIDGE_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_reads  <= '0;
         perf_writes <= '0;
         perf_stalls <= '0;
      end else begin
         if (rd_fire)
            perf_reads <= perf_reads + 32'd1;
         if (req_fire && vx_mem_req_rw)
            perf_writes <= perf_writes + 32'd1;
         if (vx_mem_req_valid && !vx_mem_req_ready)
            perf_stalls <= perf_stalls + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vx_mem_bridge.sv
// Bench for vx_mem_bridge: directed scenarios plus randomized traffic against a queue-based model.
module tb_vx_mem_bridge;

   localparam int DW = 64;
   localparam int MP = 16;

   logic          clk;
   logic          reset;
   logic          vx_mem_req_valid, vx_mem_req_ready, vx_mem_req_rw;
   logic [7:0]    vx_mem_req_byteen;
   logic [25:0]   vx_mem_req_addr;
   logic [DW-1:0] vx_mem_req_data;
   logic [7:0]    vx_mem_req_tag;
   logic          vx_mem_rsp_valid, vx_mem_rsp_ready;
   logic [DW-1:0] vx_mem_rsp_data;
   logic [7:0]    vx_mem_rsp_tag;
   logic          ext_req_valid, ext_req_ready, ext_req_rw;
   logic [7:0]    ext_req_byteen;
   logic [25:0]   ext_req_addr;
   logic [DW-1:0] ext_req_data;
   logic          ext_rsp_valid, ext_rsp_ready;
   logic [DW-1:0] ext_rsp_data;
   logic          busy, rsp_underflow;
`ifdef VX_MEM_BRIDGE_PERF_EN
   logic [31:0]   perf_reads, perf_writes, perf_stalls;
`endif

   vx_mem_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(26), .TAG_WIDTH(8), .MAX_PENDING(MP)) dut (
      .clk(clk), .reset(reset),
      .vx_mem_req_valid(vx_mem_req_valid), .vx_mem_req_ready(vx_mem_req_ready),
      .vx_mem_req_rw(vx_mem_req_rw), .vx_mem_req_byteen(vx_mem_req_byteen),
      .vx_mem_req_addr(vx_mem_req_addr), .vx_mem_req_data(vx_mem_req_data),
      .vx_mem_req_tag(vx_mem_req_tag),
      .vx_mem_rsp_valid(vx_mem_rsp_valid), .vx_mem_rsp_ready(vx_mem_rsp_ready),
      .vx_mem_rsp_data(vx_mem_rsp_data), .vx_mem_rsp_tag(vx_mem_rsp_tag),
      .ext_req_valid(ext_req_valid), .ext_req_ready(ext_req_ready),
      .ext_req_rw(ext_req_rw), .ext_req_byteen(ext_req_byteen),
      .ext_req_addr(ext_req_addr), .ext_req_data(ext_req_data),
      .ext_rsp_valid(ext_rsp_valid), .ext_rsp_ready(ext_rsp_ready),
      .ext_rsp_data(ext_rsp_data),
      .busy(busy), .rsp_underflow(rsp_underflow)
`ifdef VX_MEM_BRIDGE_PERF_EN
      , .perf_reads(perf_reads), .perf_writes(perf_writes), .perf_stalls(perf_stalls)
`endif
   );

   typedef struct packed {
      logic          rw;
      logic [7:0]    be;
      logic [25:0]   addr;
      logic [DW-1:0] data;
   } req_t;

   typedef struct packed {
      logic [7:0]    tag;
      logic [DW-1:0] data;
   } rsp_t;

   int   n_checks = 0;
   int   n_fails  = 0;
   req_t exp_req[$];
   logic [7:0] tag_q[$];
   rsp_t out_q[$];
   int   outst = 0;
   logic uf_m = 1'b0;
   int   m_reads = 0, m_writes = 0, m_stalls = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // Reference model: queues for the request register, the tag order and the response register.
   always @(negedge clk) begin
      logic vxf, rd, ef, erf, rf;
      logic [7:0] t;
      if (reset) begin
         exp_req.delete(); tag_q.delete(); out_q.delete();
         outst = 0; uf_m = 1'b0;
         m_reads = 0; m_writes = 0; m_stalls = 0;
      end else begin
         check_eq("busy", 64'(busy), 64'(exp_req.size() != 0 || outst != 0));
         check_eq("underflow", 64'(rsp_underflow), 64'(uf_m));
         check_eq("ext_req_valid", 64'(ext_req_valid), 64'(exp_req.size() != 0));
         check_eq("vx_rsp_valid", 64'(vx_mem_rsp_valid), 64'(out_q.size() != 0));
         check_eq("ext_rsp_ready", 64'(ext_rsp_ready), 64'(out_q.size() == 0 || vx_mem_rsp_ready));
         if (vx_mem_req_valid)
            check_eq("req_ready", 64'(vx_mem_req_ready),
                     64'((exp_req.size() == 0 || ext_req_ready) && (vx_mem_req_rw || outst < MP)));
         if (exp_req.size() != 0) begin
            check_eq("ext_rw", 64'(ext_req_rw), 64'(exp_req[0].rw));
            check_eq("ext_be", 64'(ext_req_byteen), 64'(exp_req[0].be));
            check_eq("ext_addr", 64'(ext_req_addr), 64'(exp_req[0].addr));
            check_eq("ext_data", ext_req_data, exp_req[0].data);
         end
         if (out_q.size() != 0) begin
            check_eq("rsp_tag", 64'(vx_mem_rsp_tag), 64'(out_q[0].tag));
            check_eq("rsp_data", vx_mem_rsp_data, out_q[0].data);
         end

         vxf = vx_mem_req_valid && vx_mem_req_ready;
         rd  = vxf && !vx_mem_req_rw;
         ef  = (exp_req.size() != 0) && ext_req_ready;
         erf = ext_rsp_valid && ext_rsp_ready;
         rf  = (out_q.size() != 0) && vx_mem_rsp_ready;
         if (ef) void'(exp_req.pop_front());
         if (vxf) exp_req.push_back({vx_mem_req_rw, vx_mem_req_byteen, vx_mem_req_addr, vx_mem_req_data});
         if (rf) void'(out_q.pop_front());
         if (erf) begin
            if (tag_q.size() != 0) t = tag_q.pop_front();
            else begin t = 8'h00; uf_m = 1'b1; end
            out_q.push_back({t, ext_rsp_data});
         end
         if (rd) tag_q.push_back(vx_mem_req_tag);
         if (rd && !rf) outst++;
         else if (!rd && rf && outst > 0) outst--;
         if (rd) m_reads++;
         if (vxf && vx_mem_req_rw) m_writes++;
         if (vx_mem_req_valid && !vx_mem_req_ready) m_stalls++;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send_req(input logic rw, input logic [7:0] tag, input logic [25:0] addr);
      int n = 0;
      vx_mem_req_valid  = 1'b1;
      vx_mem_req_rw     = rw;
      vx_mem_req_tag    = tag;
      vx_mem_req_addr   = addr;
      vx_mem_req_byteen = 8'hFF;
      vx_mem_req_data   = {$urandom, $urandom};
      #1;
      while (!vx_mem_req_ready && n < 50) begin
         cyc();
         n++;
      end
      if (!vx_mem_req_ready) check_eq("req_timeout", 64'(0), 64'(1));
      cyc();
      vx_mem_req_valid = 1'b0;
   endtask

   initial begin
      int   ext_pend = 0;
      logic req_go = 1'b0, rsp_go = 1'b0;
      logic slow, offer;

      reset = 1'b1;
      vx_mem_req_valid = 1'b0; vx_mem_req_rw = 1'b0; vx_mem_req_byteen = '0;
      vx_mem_req_addr = '0; vx_mem_req_data = '0; vx_mem_req_tag = '0;
      vx_mem_rsp_ready = 1'b1; ext_req_ready = 1'b1;
      ext_rsp_valid = 1'b0; ext_rsp_data = '0;
      repeat (3) cyc();
      check_eq("rst_req_ready", 64'(vx_mem_req_ready), 64'(0));
      check_eq("rst_rsp_ready", 64'(ext_rsp_ready), 64'(0));
      reset = 1'b0;
      #1;
      check_eq("post_rst_req_ready", 64'(vx_mem_req_ready), 64'(1));
      check_eq("post_rst_rsp_ready", 64'(ext_rsp_ready), 64'(1));
      check_eq("post_rst_ext_valid", 64'(ext_req_valid), 64'(0));
      check_eq("post_rst_busy", 64'(busy), 64'(0));

      // Single read with latency checks on both directions.
      send_req(1'b0, 8'h5A, 26'h100);
      check_eq("t1_ext_valid", 64'(ext_req_valid), 64'(1));
      check_eq("t1_ext_rw", 64'(ext_req_rw), 64'(0));
      check_eq("t1_ext_addr", 64'(ext_req_addr), 64'h100);
      cyc();
      ext_rsp_valid = 1'b1;
      ext_rsp_data  = 64'hDEAD_BEEF_DEAD_BEEF;
      cyc();
      ext_rsp_valid = 1'b0;
      check_eq("t1_rsp_valid", 64'(vx_mem_rsp_valid), 64'(1));
      check_eq("t1_rsp_tag", 64'(vx_mem_rsp_tag), 64'h5A);
      check_eq("t1_rsp_data", vx_mem_rsp_data, 64'hDEAD_BEEF_DEAD_BEEF);
      cyc();
      check_eq("t1_busy_idle", 64'(busy), 64'(0));

      // Fill all credits, then read refused but write accepted; release and watch credit reopen.
      for (int i = 0; i < MP; i++) send_req(1'b0, 8'(i), 26'(i));
      vx_mem_req_valid = 1'b1; vx_mem_req_rw = 1'b0; vx_mem_req_tag = 8'h10;
      #1;
      check_eq("credit_stall_read", 64'(vx_mem_req_ready), 64'(0));
      vx_mem_req_rw = 1'b1;
      #1;
      check_eq("credit_stall_write", 64'(vx_mem_req_ready), 64'(1));
      cyc();
      vx_mem_req_rw = 1'b0; vx_mem_req_tag = 8'h20; vx_mem_req_addr = 26'h20;
      for (int i = 0; i < MP + 1; i++) begin
         ext_rsp_valid = 1'b1;
         ext_rsp_data  = 64'h1000 + 64'(i);
         #1;
         if (i == 1) check_eq("credit_hold", 64'(vx_mem_req_ready), 64'(0));
         if (i == 2) check_eq("credit_reopen", 64'(vx_mem_req_ready), 64'(1));
         cyc();
         if (i == 2) vx_mem_req_valid = 1'b0;
      end
      ext_rsp_valid = 1'b0;
      repeat (3) cyc();
      check_eq("t2_busy_idle", 64'(busy), 64'(0));

      // Orphan external response.
      ext_rsp_valid = 1'b1;
      ext_rsp_data  = 64'hBAD0;
      cyc();
      ext_rsp_valid = 1'b0;
      check_eq("uf_rsp_tag", 64'(vx_mem_rsp_tag), 64'(0));
      check_eq("uf_flag", 64'(rsp_underflow), 64'(1));
      repeat (3) cyc();
      check_eq("uf_sticky", 64'(rsp_underflow), 64'(1));

      // Reset with three reads outstanding.
      for (int i = 0; i < 3; i++) send_req(1'b0, 8'(8'h30 + i), 26'(i));
      reset = 1'b1;
      cyc();
      check_eq("mid_rst_ext_valid", 64'(ext_req_valid), 64'(0));
      check_eq("mid_rst_rsp_valid", 64'(vx_mem_rsp_valid), 64'(0));
      check_eq("mid_rst_busy", 64'(busy), 64'(0));
      check_eq("mid_rst_uf", 64'(rsp_underflow), 64'(0));
      reset = 1'b0;
      send_req(1'b0, 8'h11, 26'h44);
      cyc();
      ext_rsp_valid = 1'b1;
      ext_rsp_data  = 64'h1111;
      cyc();
      ext_rsp_valid = 1'b0;
      check_eq("fresh_rsp_tag", 64'(vx_mem_rsp_tag), 64'h11);
      repeat (2) cyc();

      // Randomized traffic; alternating windows of slow response drain force credit stalls.
      for (int c = 0; c < 3500; c++) begin
         cyc();
         offer = (c < 3000);
         slow  = (c < 3000) && ((c / 256) % 2 == 1);
         if (!vx_mem_req_valid || req_go) begin
            vx_mem_req_valid  = offer && ($urandom_range(0, 3) != 0);
            vx_mem_req_rw     = ($urandom_range(0, 3) == 0);
            vx_mem_req_byteen = 8'($urandom);
            vx_mem_req_addr   = 26'($urandom);
            vx_mem_req_data   = {$urandom, $urandom};
            vx_mem_req_tag    = 8'($urandom);
         end
         if (!ext_rsp_valid || rsp_go) begin
            ext_rsp_valid = (ext_pend > 0) && ($urandom_range(0, 1) == 1);
            ext_rsp_data  = {$urandom, $urandom};
         end
         ext_req_ready    = ($urandom_range(0, 3) != 0);
         vx_mem_rsp_ready = slow ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
         #1;
         req_go = vx_mem_req_valid && vx_mem_req_ready;
         rsp_go = ext_rsp_valid && ext_rsp_ready;
         if (rsp_go) ext_pend--;
         if (ext_req_valid && ext_req_ready && !ext_req_rw) ext_pend++;
      end
      check_eq("drain_rsp_q", 64'(out_q.size()), 64'(0));
      check_eq("drain_tag_q", 64'(tag_q.size()), 64'(0));
      check_eq("drain_busy", 64'(busy), 64'(0));
`ifdef VX_MEM_BRIDGE_PERF_EN
      check_eq("perf_reads", 64'(perf_reads), 64'(m_reads));
      check_eq("perf_writes", 64'(perf_writes), 64'(m_writes));
      check_eq("perf_stalls", 64'(perf_stalls), 64'(m_stalls));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/vx_mem_bridge.md
# vx_mem_bridge

Bridges the Vortex top-level memory port (tagged, out-of-order-capable requests and responses) to an external in-order, untagged memory channel. It sits directly downstream of the Vortex top. It consumes `mem_req_*` and produces `mem_rsp_*` for the Vortex top. For every accepted read it stores the request tag in an in-order tag FIFO and re-attaches that tag to the matching external response. Outstanding reads are bounded by a credit counter, and the block reports `busy` while any transaction is in flight.

## Interface
Parameters:
- `DATA_WIDTH`, default 512: memory line width in bits; byte-enable width is `DATA_WIDTH/8`.
- `ADDR_WIDTH`, default 26: line address width.
- `TAG_WIDTH`, default 8: Vortex memory tag width.
- `MAX_PENDING`, default 16: maximum outstanding reads; must be a power of 2 and at least 2.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`  in  1  clock.
  - `reset`  in  1  synchronous, active-high reset.
- Vortex side, request:
  - `vx_mem_req_valid` / `vx_mem_req_ready`  in / out  1 / 1  request handshake.
  - `vx_mem_req_rw`  in  1  1 = write.
  - `vx_mem_req_byteen`  in  DATA_WIDTH/8  byte enables.
  - `vx_mem_req_addr`  in  ADDR_WIDTH  line address.
  - `vx_mem_req_data`  in  DATA_WIDTH  write data.
  - `vx_mem_req_tag`  in  TAG_WIDTH  request tag.
- Vortex side, response:
  - `vx_mem_rsp_valid` / `vx_mem_rsp_ready`  out / in  1 / 1  response handshake.
  - `vx_mem_rsp_data`  out  DATA_WIDTH  read data.
  - `vx_mem_rsp_tag`  out  TAG_WIDTH  tag of the original read.
- External side:
  - `ext_req_valid` / `ext_req_ready`  out / in  1 / 1  request handshake.
  - `ext_req_rw`, `ext_req_byteen`, `ext_req_addr`, `ext_req_data`  out  same widths as the Vortex request  registered copy of the Vortex request.
  - `ext_rsp_valid` / `ext_rsp_ready`  in / out  1 / 1  in-order read-response handshake.
  - `ext_rsp_data`  in  DATA_WIDTH  read data.
- Status:
  - `busy`  out  1  any transaction in flight.
  - `rsp_underflow`  out  1  sticky error flag.

## Operation
- Request stage: a single output register (`req_q_valid` plus payload).
  - `vx_mem_req_ready = (!req_q_valid || ext_req_ready) && (vx_mem_req_rw || pending < MAX_PENDING)`.
  - On a Vortex request fire the payload is loaded into the register. `ext_req_*` are driven from the register.
  - The register clears when the external request fires and no new request is loaded.
- Read accounting: a read fire pushes `vx_mem_req_tag` into the tag FIFO (depth `MAX_PENDING`) and increments `pending`.
  - Writes produce no response and are not counted.
- Response stage: a single output register.
  - `ext_rsp_ready = !rsp_q_valid || vx_mem_rsp_ready`.
  - On an external response fire, `ext_rsp_data` and the tag at the FIFO head are loaded into the register, and the FIFO is popped.
  - `vx_mem_rsp_valid`, `vx_mem_rsp_data` and `vx_mem_rsp_tag` are driven from the register.
- `pending` decrements on a Vortex response fire (`vx_mem_rsp_valid && vx_mem_rsp_ready`).
  - A read fire and a response fire in the same cycle leave `pending` unchanged.
  - Width of `pending` is `$clog2(MAX_PENDING)+1`; it never exceeds `MAX_PENDING`.
- Tag FIFO: circular pointers that wrap modulo `MAX_PENDING`. A simultaneous push and pop are both honoured.
  - The FIFO cannot overflow, because of the credit check.
- Underflow: an external response fire while the tag FIFO is empty sets `rsp_underflow` (sticky until reset).
  - The response is still forwarded with tag 0, and the FIFO pointers are not moved.
- `busy = req_q_valid || pending != 0`.

## Timing
- Reset values: every output valid = 0, `busy` = 0, `rsp_underflow` = 0, `pending` = 0, FIFO empty.
  - `vx_mem_req_ready` = 1 and `ext_rsp_ready` = 1 in the first cycle after reset deasserts.
- While `reset` is high, `vx_mem_req_ready` and `ext_rsp_ready` are forced to 0.
- Reset mid-operation discards the request register, the response register and all tags. External memory is reset on the same signal.
- Request latency: a Vortex request fire in cycle N gives `ext_req_valid` in cycle N+1.
- Response latency: an external response fire in cycle N gives `vx_mem_rsp_valid` in cycle N+1.
- Full throughput: one request and one response per cycle when both sides are ready.
- Credit stall: at `pending == MAX_PENDING`, reads are refused and writes still pass. A response fire in cycle N re-opens read acceptance in cycle N+1.
- Valid signals are never deasserted before their ready is seen; payloads stay stable while valid && !ready.

## Configuration
- `VX_MEM_BRIDGE_PERF_EN` defined: adds three 32-bit output ports, each wrapping on overflow and cleared by reset.
  - `perf_reads`: read fires.
  - `perf_writes`: write fires.
  - `perf_stalls`: cycles with `vx_mem_req_valid && !vx_mem_req_ready`.
- Not defined: these ports and their counters do not exist. All other behaviour is identical.

## Test plan
- Single read, tag 0x5A, addr 0x100: `ext_req_valid` one cycle after acceptance with `rw`=0. External response 0xDEAD… gives `vx_mem_rsp` with tag 0x5A one cycle later; `busy` returns to 0.
- 16 reads, tags 0x00–0x0F, with external responses withheld: the 17th read sees `vx_mem_req_ready`=0 while a write is still accepted. Releasing responses returns tags in order 0x00…0x0F.
- Back-to-back read and response with `MAX_PENDING`=4 and tags cycling past 4 entries: FIFO wrap-around preserves tag order. `pending` stays at 2 under simultaneous push and pop.
- External response with no reads outstanding: `rsp_underflow`=1 and it stays set until reset. A response with tag 0 is emitted.
- Reset asserted with 3 reads pending: the next cycle shows every valid = 0, `busy`=0, `pending`=0. A fresh read, tag 0x11, returns tag 0x11.
- With `VX_MEM_BRIDGE_PERF_EN`: 3 reads, 2 writes and 4 stall cycles give `perf_reads`=3, `perf_writes`=2, `perf_stalls`=4.
